// File: rtl/bitty_pkg.sv
// Shared opcode, FSM state and CMP-result encodings for the bitty core and its ALU.
// Any build option (BITTY_SHIFTER_EN) only changes which of these opcodes the ALU accepts.
package bitty_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_CMP = 4'd7,
    OP_MOV = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_LT = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;

endpackage

// File: rtl/bitty_alu_p.sv
// Combinational ALU: add/sub/logic/cmp/mov, plus shifts when BITTY_SHIFTER_EN is defined.
// Zero latency, no handshake; unknown or disabled opcodes raise illegal_o with y_o = 0.
module bitty_alu_p
  import bitty_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o,
  output logic             illegal_o
);

`ifdef BITTY_SHIFTER_EN
  localparam int SW = $clog2(WIDTH);
`endif

  always_comb begin
    y_o       = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD: y_o = a_i + b_i;
      OP_SUB: y_o = a_i - b_i;
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
`ifdef BITTY_SHIFTER_EN
      // Only the low log2(WIDTH) bits of B count as shift amount.
      OP_SHL: y_o = a_i << b_i[SW-1:0];
      OP_SHR: y_o = a_i >> b_i[SW-1:0];
`endif
      OP_CMP: begin
        if (a_i == b_i) begin
          y_o = WIDTH'(CMP_EQ);
        end else if (a_i < b_i) begin
          y_o = WIDTH'(CMP_LT);
        end else begin
          y_o = WIDTH'(CMP_GT);
        end
      end
      OP_MOV: y_o = b_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/bitty_core_p.sv
// Multi-cycle bitty core: IDLE->READ->EXEC->WB, result/done (or err) in WB, 4 cycles per instruction.
// instr_ready is high only in IDLE; optional shifter controlled by BITTY_SHIFTER_EN.
module bitty_core_p
  import bitty_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int RA    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OP_W-1:0]  instr_op,
  input  logic [RA-1:0]    instr_rx,
  input  logic [RA-1:0]    instr_ry,
  input  logic             instr_use_imm,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err,
  input  logic [RA-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e state_q, state_d;

  logic [OP_W-1:0]  op_q;
  logic [RA-1:0]    rx_q, ry_q;
  logic             use_imm_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] alu_q;
  logic             illegal_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q, err_q;
  logic [WIDTH-1:0] regs_q [NREGS];

  logic [WIDTH-1:0] alu_y;
  logic             alu_illegal;
  logic             hs;

  assign instr_ready = (state_q == ST_IDLE);
  assign hs          = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  bitty_alu_p #(.WIDTH(WIDTH)) u_alu (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .y_o       (alu_y),
    .illegal_o (alu_illegal)
  );

  // Operands and the ALU result are staged so each state does one thing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (hs) begin
        op_q      <= instr_op;
        rx_q      <= instr_rx;
        ry_q      <= instr_ry;
        use_imm_q <= instr_use_imm;
        imm_q     <= instr_imm;
      end
      if (state_q == ST_READ) begin
        a_q <= regs_q[rx_q];
        b_q <= use_imm_q ? imm_q : regs_q[ry_q];
      end
      // result/done/err are loaded on entry to WB so they are visible during WB.
      if (state_q == ST_EXEC) begin
        alu_q     <= alu_y;
        illegal_q <= alu_illegal;
        done_q    <= ~alu_illegal;
        err_q     <= alu_illegal;
        if (!alu_illegal) begin
          result_q <= alu_y;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == ST_WB && !illegal_q) begin
      regs_q[rx_q] <= alu_q;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign err      = err_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_bitty_core_p.sv
// Self-checking bench for bitty_core_p: per-cycle comparison against an instruction-level model,
// directed scenarios with literal expectations, then randomized instructions.
module tb_bitty_core_p;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int RA = 3;

`ifdef BITTY_SHIFTER_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [3:0]    instr_op = '0;
  logic [RA-1:0] instr_rx = '0;
  logic [RA-1:0] instr_ry = '0;
  logic          instr_use_imm = 1'b0;
  logic [W-1:0]  instr_imm = '0;
  logic [W-1:0]  result;
  logic          done;
  logic          err;
  logic [RA-1:0] dbg_addr = '0;
  logic [W-1:0]  dbg_data;

  always #5 clk = ~clk;

  bitty_core_p #(.WIDTH(W), .NREGS(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rx      (instr_rx),
    .instr_ry      (instr_ry),
    .instr_use_imm (instr_use_imm),
    .instr_imm     (instr_imm),
    .result        (result),
    .done          (done),
    .err           (err),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Instruction-level model: stage counts cycles since the handshake (0 = idle).
  logic [W-1:0] m_regs [N];
  logic [W-1:0] m_result;
  logic [W-1:0] m_val;
  bit           m_legal;
  int           m_stage;
  int           m_rx;
  int           hs_cnt = 0;
  int           cyc = 0;

  function automatic void model_alu(input int op, input int a, input int b,
                                    output bit legal, output logic [W-1:0] v);
    legal = 1'b1;
    v     = '0;
    case (op)
      0: v = W'((a + b) % 65536);
      1: v = W'((a - b + 65536) % 65536);
      2: v = W'(a & b);
      3: v = W'(a | b);
      4: v = W'(a ^ b);
      5: if (SHIFT_EN) v = W'((a << (b % 16)) % 65536); else legal = 1'b0;
      6: if (SHIFT_EN) v = W'(a >> (b % 16)); else legal = 1'b0;
      7: v = (a == b) ? 16'd0 : ((a < b) ? 16'd1 : 16'd2);
      8: v = W'(b);
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_result = '0;
    m_val    = '0;
    m_legal  = 1'b0;
    m_stage  = 0;
    m_rx     = 0;
  endtask

  task automatic m_step();
    bit was_idle;
    int a, b;
    was_idle = (m_stage == 0);
    cyc++;
    case (m_stage)
      1: m_stage = 2;
      2: begin
        m_stage = 3;
        if (m_legal) m_result = m_val;
      end
      3: begin
        m_stage = 0;
        if (m_legal) m_regs[m_rx] = m_val;
      end
      default: ;
    endcase
    if (was_idle && instr_valid) begin
      a = int'(m_regs[instr_rx]);
      b = instr_use_imm ? int'(instr_imm) : int'(m_regs[instr_ry]);
      model_alu(int'(instr_op), a, b, m_legal, m_val);
      m_rx    = int'(instr_rx);
      m_stage = 1;
      hs_cnt++;
    end
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_clear();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ready",  32'(instr_ready), 32'(m_stage == 0));
      chk("done",   32'(done),        32'(m_stage == 3 && m_legal));
      chk("err",    32'(err),         32'(m_stage == 3 && !m_legal));
      chk("result", 32'(result),      32'(m_result));
      chk("dbg",    32'(dbg_data),    32'(m_regs[dbg_addr]));
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_chk(input string name, input int addr, input logic [W-1:0] exp);
    dbg_addr = RA'(addr);
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  // Called at #1 after a rising edge while idle; returns in the following IDLE cycle.
  task automatic issue(input int op, input int rx, input int ry, input bit ui,
                       input logic [W-1:0] imm, output bit d_seen, output bit e_seen);
    int base;
    bit got;
    base = hs_cnt;
    got  = 1'b0;
    instr_op      = 4'(op);
    instr_rx      = RA'(rx);
    instr_ry      = RA'(ry);
    instr_use_imm = ui;
    instr_imm     = imm;
    instr_valid   = 1'b1;
    for (int k = 0; k < 16 && !got; k++) begin
      sync();
      got = (hs_cnt != base);
    end
    chk("handshake", 32'(got), 32'd1);
    instr_valid   = 1'b0;
    instr_op      = 4'($urandom);
    instr_rx      = RA'($urandom);
    instr_ry      = RA'($urandom);
    instr_use_imm = 1'($urandom);
    instr_imm     = W'($urandom);
    sync();
    sync();
    d_seen = done;
    e_seen = err;
    sync();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t, required finish before 500000", $time);
    $fatal(1);
  end

  initial begin
    bit d, e, seen;
    int base, n_done;
    int dcyc [3];
    int op;

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < N; i++) dbg_chk("reset_reg", i, 16'h0000);
    chk("reset_ready",  32'(instr_ready), 32'd1);
    chk("reset_result", 32'(result),      32'd0);
    sync();

    issue(8, 1, 0, 1'b1, 16'h00FF, d, e);
    chk("mov_done", 32'(d), 32'd1);
    chk("mov_result", 32'(result), 32'h00FF);
    dbg_chk("mov_r1", 1, 16'h00FF);
    sync();
    issue(0, 1, 0, 1'b1, 16'hFF01, d, e);
    chk("add_wrap", 32'(result), 32'h0000);

    issue(8, 2, 0, 1'b1, 16'd5, d, e);
    issue(8, 3, 0, 1'b1, 16'd9, d, e);
    issue(7, 2, 3, 1'b0, 16'h0000, d, e);
    chk("cmp_lt", 32'(result), 32'd1);
    issue(8, 2, 0, 1'b1, 16'd5, d, e);
    issue(1, 2, 3, 1'b0, 16'h0000, d, e);
    chk("sub_neg", 32'(result), 32'hFFFC);
    issue(7, 3, 3, 1'b0, 16'h0000, d, e);
    chk("cmp_eq_self", 32'(result), 32'd0);

    issue(8, 1, 0, 1'b1, 16'h00FF, d, e);
    issue(5, 1, 0, 1'b1, 16'h0014, d, e);
    chk("shl_err", 32'(e), 32'(!SHIFT_EN));
    chk("shl_result", 32'(result), SHIFT_EN ? 32'h0FF0 : 32'h00FF);
    dbg_chk("shl_r1", 1, SHIFT_EN ? 16'h0FF0 : 16'h00FF);
    sync();

    issue(12, 1, 2, 1'b0, 16'h1234, d, e);
    chk("illegal_err",  32'(e), 32'd1);
    chk("illegal_done", 32'(d), 32'd0);
    chk("illegal_result", 32'(result), SHIFT_EN ? 32'h0FF0 : 32'h00FF);
    dbg_chk("illegal_r1", 1, SHIFT_EN ? 16'h0FF0 : 16'h00FF);
    sync();

    base          = hs_cnt;
    n_done        = 0;
    instr_op      = 4'd0;
    instr_rx      = 3'd4;
    instr_ry      = 3'd0;
    instr_use_imm = 1'b1;
    instr_imm     = 16'd1;
    instr_valid   = 1'b1;
    for (int k = 0; k < 60 && hs_cnt < base + 4; k++) begin
      sync();
      if (done) begin
        if (n_done < 3) dcyc[n_done] = cyc;
        n_done++;
      end
    end
    chk("b2b_handshakes", 32'(hs_cnt - base), 32'd4);
    chk("b2b_ndone", 32'(n_done), 32'd3);
    chk("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'd4);
    chk("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'd4);
    dbg_chk("b2b_r4", 4, 16'd3);
    sync();
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    seen        = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sync();
      seen = seen | done | err;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sync();
      seen = seen | done | err;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    dbg_chk("abort_r4", 4, 16'd0);
    chk("abort_result", 32'(result), 32'd0);
    sync();

    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      issue(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 20)) : W'($urandom), d, e);
      dbg_addr = RA'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (2) sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitty_core_p.md
# bitty_core_p

Parametrised successor to the fixed 16-bit bitty datapath: a multi-cycle, instruction-driven core with an `NREGS` × `WIDTH` register file, a full ALU and shifter, and a valid/ready instruction handshake. Each accepted instruction reads two operands (`rx`, and `ry` or an immediate), computes, and writes the result back to `rx`. It then presents the value on `result` with a one-cycle `done` pulse. The core sits between the instruction sequencer and the result sink.

## Interface
- `WIDTH`, 16: datapath and register width; must be ≥ 4.
- `NREGS`, 8: number of registers; a power of two, ≥ 2.
- `RA` (localparam), `$clog2(NREGS)`: register address width.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `instr_valid` input 1: an instruction is offered.
- `instr_ready` output 1: the core can accept an instruction.
- `instr_op` input 4: opcode.
- `instr_rx` input RA: destination register and first operand.
- `instr_ry` input RA: second-operand register.
- `instr_use_imm` input 1: when 1, operand B is `instr_imm` instead of `regs[ry]`.
- `instr_imm` input WIDTH: immediate value.
- `result` output WIDTH: last computed value; held until the next completion.
- `done` output 1: one-cycle pulse when `result` updates.
- `err` output 1: one-cycle pulse, in place of `done`, for an illegal opcode.
- `dbg_addr` input RA: debug read address.
- `dbg_data` output WIDTH: `regs[dbg_addr]`, combinational.

## Operation
- FSM states and transitions:
  - IDLE → READ on handshake (`instr_valid & instr_ready`).
  - READ → EXEC → WB → IDLE, unconditionally.
- `instr_ready` = (state == IDLE). Instruction fields are captured into internal registers at the handshake edge; input changes afterwards are ignored.
- READ: latch A = `regs[rx]`, and B = `instr_imm` or `regs[ry]` according to `use_imm`.
- EXEC: ALU computes into the internal `alu_q` register.
- WB: write `alu_q` to `regs[rx]` and to `result`, and pulse `done`. For an illegal opcode, make no write, leave `result` unchanged, and pulse `err`.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: A << B[RA'?]. The shift amount is B[$clog2(WIDTH)-1:0].
  - 6 SHR: logical right shift, same amount rule as SHL.
  - 7 CMP: 0 if A==B, 1 if A<B unsigned, 2 if A>B; zero-extended.
  - 8 MOV: B.
  - 9–15: illegal.
- Arithmetic is modulo 2^WIDTH; carry and borrow are discarded.
- rx == ry is legal; both operands read the same pre-instruction value.
- A write to `rx` is visible to the next instruction's READ.
- `dbg_data` reflects the write one cycle after the WB edge.

## Timing
- Handshake at edge N. READ occurs in cycle N+1, EXEC in N+2, WB in N+3.
- `done`/`err` are high during cycle N+3; `result` is valid from N+3 onward.
- `instr_ready` falls after edge N and is high again in cycle N+4. Maximum throughput is one instruction per 4 cycles.
- Reset values: state IDLE, `instr_ready` 1, `result` 0, `done` 0, `err` 0, all registers 0.
- Reset mid-operation (any state) aborts the instruction: no writeback, and no `done`/`err`.
- `instr_valid` may stay high continuously; the next instruction is taken in the first IDLE cycle.

## Configuration
- Macro `BITTY_SHIFTER_EN`.
  - Defined: SHL and SHR are implemented as specified above.
  - Undefined: the shifter is not synthesised; opcodes 5 and 6 are treated as illegal (`err` pulse, no writeback). All other opcodes are unchanged.

## Structure
- Package `bitty_pkg`:
  - opcode enum (`OP_ADD` … `OP_MOV`);
  - FSM state enum;
  - CMP result constants (`CMP_EQ`=0, `CMP_LT`=1, `CMP_GT`=2).
- Sub-module `bitty_alu_p`: combinational, parameterised by `WIDTH`. Inputs are op, A and B; outputs are the result and an `illegal` flag. The shifter lives inside it under `BITTY_SHIFTER_EN`.
- The core holds the FSM, the register file, the operand latches and the output registers.

## Test plan
- Reset, then `dbg_addr`=0..7 → every `dbg_data`=0, `instr_ready`=1, `result`=0.
- MOV r1, imm 0x00FF → `done` 3 cycles after the handshake, `result`=0x00FF, `regs[1]`=0x00FF. Then ADD r1, imm 0xFF01 → `result`=0x0000 (wrap).
- r2=5, r3=9: CMP r2,r3 → 1. SUB r2,r3 → 0xFFFC.
- SHL r1 (=0x00FF), imm 0x0014 → shift amount 4 → 0x0FF0. Without `BITTY_SHIFTER_EN` → `err` pulse, `regs[1]` unchanged.
- Opcode 12 → `err` pulse, no `done`, `result` and registers unchanged.
- Hold `instr_valid` high for 3 back-to-back ADD r4, imm 1 → `done` every 4 cycles, final r4=3. Assert `reset_n`=0 during the EXEC of a fourth instruction → no `done`, r4 = 0 after reset.
